wshb_arbiter: RTL

WSHB_ARBITER -- requirements
Module: wshb_arbiter

---
 rtl/wshb_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wshb_arbiter.sv
// Two-master Wishbone classic arbiter in front of a single shared slave (SDRAM).
// Round-robin on ties; an owner yields after BURST_MAX acks only if the other master waits.
module wshb_arbiter #(
    parameter int BURST_MAX = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_cyc,
    input  logic [1:0]  m_stb,
    input  logic [1:0]  m_we,
    input  logic [63:0] m_adr,
    input  logic [63:0] m_dat_ms,
    input  logic [7:0]  m_sel,
    output logic [1:0]  m_ack,
    output logic [31:0] m_dat_sm,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_ms,
    output logic [3:0]  s_sel,
    input  logic        s_ack,
    input  logic [31:0] s_dat_sm,
    output logic [1:0]  grant
);

    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            last;
    logic [CW-1:0]   cnt;
    logic            burst_done;

    // The ack that completes the burst is the one that lets a waiting master in.
    assign burst_done = s_ack && (cnt == CNT_LAST);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (m_cyc[0] && (!m_cyc[1] || last))
                    next_state = G0;
                else if (m_cyc[1])
                    next_state = G1;
            end
            G0: begin
                if (!m_cyc[0] || (burst_done && m_cyc[1]))
                    next_state = IDLE;
            end
            G1: begin
                if (!m_cyc[1] || (burst_done && m_cyc[0]))
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                cnt <= '0;
                if (next_state == G0)
                    last <= 1'b0;
                else if (next_state == G1)
                    last <= 1'b1;
            end else if (s_ack && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Slave-side mux follows the registered owner only, so a grant change never glitches mid-cycle.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        m_ack    = 2'b00;
        grant    = 2'b00;
        case (state)
            G0: begin
                s_cyc    = m_cyc[0];
                s_stb    = m_stb[0];
                s_we     = m_we[0];
                s_adr    = m_adr[31:0];
                s_dat_ms = m_dat_ms[31:0];
                s_sel    = m_sel[3:0];
                m_ack    = {1'b0, s_ack};
                grant    = 2'b01;
            end
            G1: begin
                s_cyc    = m_cyc[1];
                s_stb    = m_stb[1];
                s_we     = m_we[1];
                s_adr    = m_adr[63:32];
                s_dat_ms = m_dat_ms[63:32];
                s_sel    = m_sel[7:4];
                m_ack    = {s_ack, 1'b0};
                grant    = 2'b10;
            end
            default: ;
        endcase
    end

    assign m_dat_sm = s_dat_sm;

endmodule
